inst_buffer: RTL
================

// Module: inst_buffer
// PURPOSE
//   Front-end instruction queue; transmitting end of the front->decoder interface. Buffers up to
//   DECODER_WIDTH fetched instructions per cycle with branch-prediction and exception sideband.
//   Presents the oldest DECODER_WIDTH entries to the decoder, which registers them when !pause.
//   Decouples fetch bubbles from decode stalls.
// PARAMETERS
//   DECODER_WIDTH  2   lanes per enqueue/dequeue (pipeline_types constant; fixed at 2)
//   DEPTH          16  queue entries; power of two, >= 2*DECODER_WIDTH
// PORTS
//   clk                  in   1        single clock, rising edge
//   rst_n                in   1        asynchronous, active-low reset
//   flush                in   1        ctrl: discard all queued entries
//   pause                in   1        ctrl: decoder holding, no dequeue this cycle
//   fetch_valid[W]       in   1 each   lane i carries an instruction; lanes contiguous from 0
//   fetch_pc[W]          in   32       instruction PC
//   fetch_inst[W]        in   32       instruction word
//   fetch_pre_is_branch[W], fetch_pre_is_branch_taken[W]  in  1  predictor flags
//   fetch_pre_branch_addr[W]  in  32   predicted target
//   fetch_is_exception[W]     in  6    per-stage exception flags
//   fetch_exception_cause[W]  in  6x7  per-stage exception causes
//   fetch_ready          out  1        buffer accepts a full W-lane group this cycle
//   pc/inst/pre_is_branch/pre_is_branch_taken/pre_branch_addr/is_exception/exception_cause[W]
//                        out  as inputs  head entries to decoder, lane 0 = oldest
//   inst_valid[W]        out  1 each   lane i holds a real instruction
// BEHAVIOUR
//   - Storage: circular array, head/tail pointers log2(DEPTH) bits (wrap modulo DEPTH), count
//     register 0..DEPTH.
//   - Reset (rst_n=0, async): head=tail=count=0; all data outputs 0, inst_valid=0,
//     fetch_ready=1 once count=0 is visible (writes ignored while rst_n=0).
//   - fetch_ready = (count <= DEPTH-W), computed from current count (pre-dequeue); pure comb.
//   - Enqueue: when fetch_ready && !flush, enq_n = popcount(fetch_valid); lane i written to
//     tail+i; tail += enq_n. fetch_valid non-contiguous (0b10) is illegal; assert in sim.
//     fetch_valid with !fetch_ready is ignored (fetch must hold and retry).
//   - Output: lane i shows entry head+i when i < count, else all fields 0 and inst_valid[i]=0.
//     Combinational from storage; zero added latency; decoder's register gives 1-cycle latency.
//   - Dequeue: when !pause && !flush, deq_n = min(count, W); head += deq_n.
//     When pause=1, head and outputs are stable.
//   - Simultaneous enq/deq: count_next = count + enq_n - deq_n; entry enqueued this cycle is
//     never visible on outputs the same cycle (no bypass).
//   - Flush: next cycle head=tail=count=0; same-cycle enqueue dropped; flush wins over pause.
//   - Full: count=DEPTH-1 -> fetch_ready=0 (W=2). Empty: all inst_valid=0; pause irrelevant.
//   - Wrap: pointer and lane index (head+i, tail+i) taken modulo DEPTH; a 2-lane group may
//     straddle entry DEPTH-1/0.
//   - No state machine beyond pointers/count; no reset-mid-operation recovery beyond async
//     clear.
// TESTING
//   1 Reset then enqueue {0x1c000000, 0x1c000004} with pause=0 -> next cycle inst_valid=2'b11,
//     pc[0]=0x1c000000; following cycle count=0, inst_valid=0.
//   2 pause=1, enqueue 8 groups of 2 (DEPTH=16) -> fetch_ready falls after count reaches 16
//     (ready=0 at count>=15); outputs hold oldest pair throughout; 9th group not accepted.
//   3 From full, release pause, keep enqueuing pairs -> one pair dequeued/cycle in PC order,
//     no drop/dup across head/tail wrap at entry 15->0.
//   4 count=1, pause=0, fetch_valid=2'b01 -> inst_valid=2'b01, lane1 fields 0; count stays 1.
//   5 count=6 with pause=1, assert flush with fetch_valid=2'b11 -> next cycle count=0,
//     inst_valid=0, new pair dropped.
//   6 Entry with is_exception=6'b000001, cause[0]=7'h08, pre_is_branch_taken=1,
//     pre_branch_addr=0x1c000100 -> fields appear unchanged at corresponding output lane.

Source files
------------

// File: rtl/inst_buffer.sv
// Front-end instruction queue: circular buffer between fetch and decode.
// Each cycle it accepts up to DECODER_WIDTH instructions and presents the oldest DECODER_WIDTH to the decoder.
module inst_buffer #(
  parameter int DECODER_WIDTH = 2,
  parameter int DEPTH         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             pause,
  input  logic             fetch_valid               [DECODER_WIDTH],
  input  logic [31:0]      fetch_pc                  [DECODER_WIDTH],
  input  logic [31:0]      fetch_inst                [DECODER_WIDTH],
  input  logic             fetch_pre_is_branch       [DECODER_WIDTH],
  input  logic             fetch_pre_is_branch_taken [DECODER_WIDTH],
  input  logic [31:0]      fetch_pre_branch_addr     [DECODER_WIDTH],
  input  logic [5:0]       fetch_is_exception        [DECODER_WIDTH],
  input  logic [5:0][6:0]  fetch_exception_cause     [DECODER_WIDTH],
  output logic             fetch_ready,
  output logic [31:0]      pc                        [DECODER_WIDTH],
  output logic [31:0]      inst                      [DECODER_WIDTH],
  output logic             pre_is_branch             [DECODER_WIDTH],
  output logic             pre_is_branch_taken       [DECODER_WIDTH],
  output logic [31:0]      pre_branch_addr           [DECODER_WIDTH],
  output logic [5:0]       is_exception              [DECODER_WIDTH],
  output logic [5:0][6:0]  exception_cause           [DECODER_WIDTH],
  output logic             inst_valid                [DECODER_WIDTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            pre_is_branch;
    logic            pre_is_branch_taken;
    logic [31:0]     pre_branch_addr;
    logic [5:0]      is_exception;
    logic [5:0][6:0] exception_cause;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head_ent [DECODER_WIDTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;
  logic             enq_en;

  // Ready looks only at the pre-dequeue count so it never depends on pause.
  assign fetch_ready = (count <= CNT_W'(DEPTH - DECODER_WIDTH));
  assign enq_en      = fetch_ready && !flush;

  always_comb begin
    enq_n = '0;
    for (int i = 0; i < DECODER_WIDTH; i++)
      if (fetch_valid[i]) enq_n = enq_n + CNT_W'(1);
    deq_n = '0;
    if (!pause && !flush)
      deq_n = (count < CNT_W'(DECODER_WIDTH)) ? count : CNT_W'(DECODER_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + deq_n[PTR_W-1:0];
      if (enq_en) begin
        tail  <= tail + enq_n[PTR_W-1:0];
        count <= count + enq_n - deq_n;
      end else begin
        count <= count - deq_n;
      end
    end
  end

  // Storage carries no reset; an entry only becomes visible once count covers it.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      for (int i = 0; i < DECODER_WIDTH; i++)
        if (fetch_valid[i])
          mem[tail + PTR_W'(i)] <= '{fetch_pc[i], fetch_inst[i], fetch_pre_is_branch[i],
                                     fetch_pre_is_branch_taken[i], fetch_pre_branch_addr[i],
                                     fetch_is_exception[i], fetch_exception_cause[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (enq_en) begin
      for (int i = 1; i < DECODER_WIDTH; i++)
        assert (!fetch_valid[i] || fetch_valid[i-1]);
    end
  end

  always_comb begin
    for (int i = 0; i < DECODER_WIDTH; i++) begin
      head_ent[i]   = '0;
      inst_valid[i] = 1'b0;
      if (CNT_W'(i) < count) begin
        head_ent[i]   = mem[head + PTR_W'(i)];
        inst_valid[i] = 1'b1;
      end
      pc[i]                  = head_ent[i].pc;
      inst[i]                = head_ent[i].inst;
      pre_is_branch[i]       = head_ent[i].pre_is_branch;
      pre_is_branch_taken[i] = head_ent[i].pre_is_branch_taken;
      pre_branch_addr[i]     = head_ent[i].pre_branch_addr;
      is_exception[i]        = head_ent[i].is_exception;
      exception_cause[i]     = head_ent[i].exception_cause;
    end
  end

endmodule
